// File: rtl/alu_pkg.sv
// Shared opcode encoding and status-byte bit positions for the Z80 ALU.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLL   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SLA   = 4'd7,
        ALU_SRA   = 4'd8,
        ALU_ROL   = 4'd9,
        ALU_ROR   = 4'd10,
        ALU_INC   = 4'd11,
        ALU_DEC   = 4'd12,
        ALU_SET   = 4'd13,
        ALU_RESET = 4'd14,
        ALU_TEST  = 4'd15
    } alu_op;

    localparam int FLAG_S  = 7;
    localparam int FLAG_Z  = 6;
    localparam int FLAG_Y  = 5;
    localparam int FLAG_H  = 4;
    localparam int FLAG_X  = 3;
    localparam int FLAG_PV = 2;
    localparam int FLAG_N  = 1;
    localparam int FLAG_C  = 0;

endpackage

// File: rtl/alu_shifter.sv
// Combinational shift/rotate unit with carry-out; purely combinational, no state.
module alu_shifter
    import alu_pkg::*;
#(
    parameter int alu_width = 8
) (
    input  alu_op                 op,
    input  logic [alu_width-1:0]  a,
    input  logic [alu_width-1:0]  b,
    output logic [alu_width-1:0]  res,
    output logic                  carry
);

    localparam int W = alu_width;
    localparam logic [W-1:0] W_VAL = W'(W);

    logic [W:0]          lsh;
    logic [W:0]          rsh;
    logic signed [W:0]   sa;
    logic signed [W:0]   ash;
    logic [W-1:0]        amt;
    logic [2*W-1:0]      rol_dbl;
    logic [2*W-1:0]      ror_dbl;

    // One guard bit beside the operand catches the last bit shifted out;
    // shifting past the guard naturally yields zero (or sign) carry.
    always_comb begin
        sa      = {a, 1'b0};
        lsh     = {1'b0, a} << b;
        rsh     = {a, 1'b0} >> b;
        ash     = sa >>> b;
        amt     = b % W_VAL;
        rol_dbl = {a, a} << amt;
        ror_dbl = {a, a} >> amt;
        res     = a;
        carry   = 1'b0;
        case (op)
            ALU_SLL, ALU_SLA: begin
                res   = lsh[W-1:0];
                carry = lsh[W];
            end
            ALU_SRL: begin
                res   = rsh[W:1];
                carry = rsh[0];
            end
            ALU_SRA: begin
                res   = ash[W:1];
                carry = ash[0];
            end
            ALU_ROL: begin
                res   = rol_dbl[2*W-1:W];
                carry = (amt != '0) & rol_dbl[W];
            end
            ALU_ROR: begin
                res   = ror_dbl[W-1:0];
                carry = (amt != '0) & ror_dbl[W-1];
            end
            default: begin
                res   = a;
                carry = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/z80_alu.sv
// Registered 16-op ALU producing a result and Z80-layout flags (S Z Y H X P/V N C).
// One-cycle latency, no handshake; enable=0 holds both output registers.
module z80_alu
    import alu_pkg::*;
#(
    parameter int alu_width = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [alu_width-1:0]  a,
    input  logic [alu_width-1:0]  b,
    input  alu_op                 opcode,
    output logic [alu_width-1:0]  out,
    output logic [7:0]            status_flag
);

    localparam int W = alu_width;
    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] out_q, out_d;
    logic [7:0]   flag_q, flag_d;

    logic [W-1:0] sh_res;
    logic         sh_carry;

    logic         is_sub;
    logic [W-1:0] y;
    logic [W:0]   arith;
    logic [4:0]   nib;
    logic         ovf;
    logic [W-1:0] bit_mask;
    logic [W-1:0] res;
    logic [7:0]   f;

    alu_shifter #(.alu_width(W)) u_shifter (
        .op    (opcode),
        .a     (a),
        .b     (b),
        .res   (sh_res),
        .carry (sh_carry)
    );

    // INC/DEC reuse the adder with a constant 1 operand so H and V match ADD/SUB.
    always_comb begin
        is_sub = (opcode == ALU_SUB) || (opcode == ALU_DEC);
        y      = ((opcode == ALU_INC) || (opcode == ALU_DEC)) ? ONE : b;
        if (is_sub) begin
            arith = {1'b0, a} - {1'b0, y};
            nib   = {1'b0, a[3:0]} - {1'b0, y[3:0]};
            ovf   = (a[W-1] ^ y[W-1]) & (arith[W-1] ^ a[W-1]);
        end else begin
            arith = {1'b0, a} + {1'b0, y};
            nib   = {1'b0, a[3:0]} + {1'b0, y[3:0]};
            ovf   = ~(a[W-1] ^ y[W-1]) & (arith[W-1] ^ a[W-1]);
        end
    end

    always_comb begin
        bit_mask = ONE << b[2:0];
        res      = a;
        case (opcode)
            ALU_ADD, ALU_SUB, ALU_INC, ALU_DEC: res = arith[W-1:0];
            ALU_AND:   res = a & b;
            ALU_OR:    res = a | b;
            ALU_XOR:   res = a ^ b;
            ALU_SLL, ALU_SLA, ALU_SRL, ALU_SRA,
            ALU_ROL, ALU_ROR:                   res = sh_res;
            ALU_SET:   res = a | bit_mask;
            ALU_RESET: res = a & ~bit_mask;
            default:   res = a;
        endcase

        f          = 8'h00;
        f[FLAG_S]  = res[W-1];
        f[FLAG_Z]  = (res == '0);
        f[FLAG_Y]  = res[5];
        f[FLAG_X]  = res[3];
        f[FLAG_PV] = ~^res;
        case (opcode)
            ALU_ADD, ALU_SUB: begin
                f[FLAG_H]  = nib[4];
                f[FLAG_PV] = ovf;
                f[FLAG_N]  = is_sub;
                f[FLAG_C]  = arith[W];
            end
            ALU_INC, ALU_DEC: begin
                f[FLAG_H]  = nib[4];
                f[FLAG_PV] = ovf;
                f[FLAG_N]  = is_sub;
                f[FLAG_C]  = flag_q[FLAG_C];
            end
            ALU_AND: f[FLAG_H] = 1'b1;
            ALU_SLL, ALU_SLA, ALU_SRL, ALU_SRA,
            ALU_ROL, ALU_ROR: f[FLAG_C] = sh_carry;
            ALU_SET, ALU_RESET: f = flag_q;
            ALU_TEST: begin
                f[FLAG_Z] = ~a[b[2:0]];
                f[FLAG_H] = 1'b1;
                f[FLAG_C] = flag_q[FLAG_C];
            end
            default: f[FLAG_C] = 1'b0;
        endcase

        out_d  = out_q;
        flag_d = flag_q;
        if (enable) begin
            out_d  = res;
            flag_d = f;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q  <= '0;
            flag_q <= 8'h00;
        end else begin
            out_q  <= out_d;
            flag_q <= flag_d;
        end
    end

    assign out         = out_q;
    assign status_flag = flag_q;

endmodule

// File: tb/tb_z80_alu.sv
// Directed-vector scoreboard bench for z80_alu (8-bit width).
module tb_z80_alu;
    import alu_pkg::*;

    typedef struct {
        string      name;
        logic [7:0] out;
        logic [7:0] flg;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] a;
    logic [7:0] b;
    alu_op      opcode;
    logic [7:0] out;
    logic [7:0] status_flag;

    exp_t exp_q[$];
    logic chk   = 1'b0;
    logic chk_q = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;

    z80_alu #(.alu_width(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .a           (a),
        .b           (b),
        .opcode      (opcode),
        .out         (out),
        .status_flag (status_flag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) chk_q <= chk;

    always @(negedge clk) begin
        if (chk_q) begin
            exp_t e;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL scoreboard_underflow: output presented with no expected entry");
            end else begin
                e = exp_q.pop_front();
                if (out !== e.out || status_flag !== e.flg) begin
                    n_bad++;
                    $display("FAIL %s: out=%02h flags=%02h, expected out=%02h flags=%02h",
                             e.name, out, status_flag, e.out, e.flg);
                end
            end
        end
    end

    task automatic vec(input alu_op op, input logic [7:0] av, input logic [7:0] bv,
                       input logic en, input logic rst, input string nm,
                       input logic [7:0] eo, input logic [7:0] ef);
        exp_t e;
        @(negedge clk);
        opcode = op;
        a      = av;
        b      = bv;
        enable = en;
        reset  = rst;
        chk    = 1'b1;
        e.name = nm;
        e.out  = eo;
        e.flg  = ef;
        exp_q.push_back(e);
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        a      = 8'h00;
        b      = 8'h00;
        opcode = ALU_ADD;

        vec(ALU_ADD, 8'h00, 8'h00, 1'b1, 1'b1, "reset_state", 8'h00, 8'h00);

        vec(ALU_ADD, 8'h07, 8'h07, 1'b1, 1'b0, "add_7_7",     8'h0E, 8'h08);
        vec(ALU_ADD, 8'hFF, 8'h01, 1'b1, 1'b0, "add_ff_01",   8'h00, 8'h51);
        vec(ALU_ADD, 8'h70, 8'h47, 1'b1, 1'b0, "add_70_47",   8'hB7, 8'hA4);
        vec(ALU_ADD, 8'hFF, 8'h80, 1'b1, 1'b0, "add_ff_80",   8'h7F, 8'h2D);
        vec(ALU_SUB, 8'h07, 8'h07, 1'b1, 1'b0, "sub_7_7",     8'h00, 8'h42);
        vec(ALU_SUB, 8'hFE, 8'hFF, 1'b1, 1'b0, "sub_fe_ff",   8'hFF, 8'hBB);
        vec(ALU_SUB, 8'h0D, 8'h10, 1'b1, 1'b0, "sub_0d_10",   8'hFD, 8'hAB);
        vec(ALU_SUB, 8'h80, 8'h01, 1'b1, 1'b0, "sub_80_01",   8'h7F, 8'h3E);
        vec(ALU_SUB, 8'h00, 8'hFF, 1'b1, 1'b0, "sub_00_ff",   8'h01, 8'h13);

        vec(ALU_AND, 8'h0D, 8'h07, 1'b1, 1'b0, "and_0d_07",   8'h05, 8'h14);
        vec(ALU_OR,  8'hCB, 8'h2B, 1'b1, 1'b0, "or_cb_2b",    8'hEB, 8'hAC);
        vec(ALU_XOR, 8'hFF, 8'h8A, 1'b1, 1'b0, "xor_ff_8a",   8'h75, 8'h20);
        vec(ALU_XOR, 8'h07, 8'h07, 1'b1, 1'b0, "xor_7_7",     8'h00, 8'h44);

        vec(ALU_SLL, 8'h07, 8'd3,  1'b1, 1'b0, "sll_07_3",    8'h38, 8'h28);
        vec(ALU_SLL, 8'h0F, 8'd6,  1'b1, 1'b0, "sll_0f_6",    8'hC0, 8'h85);
        vec(ALU_SLA, 8'h0F, 8'd9,  1'b1, 1'b0, "sla_0f_9",    8'h00, 8'h44);
        vec(ALU_SRL, 8'hCA, 8'd3,  1'b1, 1'b0, "srl_ca_3",    8'h19, 8'h08);
        vec(ALU_SRL, 8'hCA, 8'd8,  1'b1, 1'b0, "srl_ca_8",    8'h00, 8'h45);
        vec(ALU_SRA, 8'hCA, 8'd3,  1'b1, 1'b0, "sra_ca_3",    8'hF9, 8'hAC);
        vec(ALU_SRA, 8'h4A, 8'd3,  1'b1, 1'b0, "sra_4a_3",    8'h09, 8'h0C);
        vec(ALU_SRA, 8'hCA, 8'd8,  1'b1, 1'b0, "sra_ca_8",    8'hFF, 8'hAD);
        vec(ALU_SLL, 8'h02, 8'd0,  1'b1, 1'b0, "sll_02_0",    8'h02, 8'h00);
        vec(ALU_SLL, 8'h03, 8'd0,  1'b1, 1'b0, "sll_03_0",    8'h03, 8'h04);

        vec(ALU_ROL, 8'hCA, 8'd3,  1'b1, 1'b0, "rol_ca_3",    8'h56, 8'h04);
        vec(ALU_ROL, 8'h80, 8'd10, 1'b1, 1'b0, "rol_80_10",   8'h02, 8'h00);
        vec(ALU_ROR, 8'hCA, 8'd3,  1'b1, 1'b0, "ror_ca_3",    8'h59, 8'h0C);
        vec(ALU_ROR, 8'h80, 8'd10, 1'b1, 1'b0, "ror_80_10",   8'h20, 8'h20);
        vec(ALU_ROL, 8'h81, 8'd1,  1'b1, 1'b0, "rol_81_1",    8'h03, 8'h05);
        vec(ALU_ROR, 8'h01, 8'd1,  1'b1, 1'b0, "ror_01_1",    8'h80, 8'h81);

        // Carry set here must survive INC/DEC/SET/RESET/TEST and the enable=0 gap.
        vec(ALU_ADD,   8'hFF, 8'h01, 1'b1, 1'b0, "set_carry",  8'h00, 8'h51);
        vec(ALU_INC,   8'hFF, 8'h00, 1'b1, 1'b0, "inc_ff",     8'h00, 8'h51);
        vec(ALU_INC,   8'h7F, 8'h00, 1'b1, 1'b0, "inc_7f",     8'h80, 8'h95);
        vec(ALU_DEC,   8'h80, 8'h00, 1'b1, 1'b0, "dec_80",     8'h7F, 8'h3F);
        vec(ALU_SET,   8'h00, 8'd7,  1'b1, 1'b0, "set_00_b7",  8'h80, 8'h3F);
        vec(ALU_RESET, 8'hFF, 8'h08, 1'b1, 1'b0, "res_ff_b0",  8'hFE, 8'h3F);
        vec(ALU_TEST,  8'h80, 8'd6,  1'b1, 1'b0, "test_80_b6", 8'h80, 8'hD1);
        vec(ALU_TEST,  8'h80, 8'd7,  1'b1, 1'b0, "test_80_b7", 8'h80, 8'h91);

        vec(ALU_ADD, 8'h12, 8'h34, 1'b0, 1'b0, "hold_1", 8'h80, 8'h91);
        vec(ALU_SUB, 8'h55, 8'hAA, 1'b0, 1'b0, "hold_2", 8'h80, 8'h91);
        vec(ALU_XOR, 8'hF0, 8'h0F, 1'b0, 1'b0, "hold_3", 8'h80, 8'h91);

        vec(ALU_INC, 8'h00, 8'h00, 1'b1, 1'b0, "inc_00_c1",  8'h01, 8'h01);
        vec(ALU_DEC, 8'h01, 8'h00, 1'b1, 1'b0, "dec_01_c1",  8'h00, 8'h43);

        vec(ALU_ADD, 8'h07, 8'h07, 1'b1, 1'b1, "reset_mid",  8'h00, 8'h00);
        vec(ALU_INC, 8'h00, 8'h00, 1'b1, 1'b0, "inc_after_reset", 8'h01, 8'h00);

        @(negedge clk);
        chk    = 1'b0;
        enable = 1'b0;
        repeat (3) @(negedge clk);

        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/z80_alu.md
# z80_alu

Registered, parameterised-width integer ALU for the Z80 datapath core, module name `z80_alu`. It sits between the register file/operand muxes and the result/flag write-back path. Each enabled cycle it executes one of 16 operations on operands `a` and `b`, then registers an `alu_width`-bit result and a Z80-layout 8-bit status byte.

## Interface
- `alu_width`, default 8: operand/result width. Must be ≥ 8.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  when 1, the operation is captured at the next edge; when 0, `out` and `status_flag` hold.
- `a`  in  alu_width  first operand; the operand that is shifted, rotated or bit-tested.
- `b`  in  alu_width  second operand; shift/rotate amount; bit index in `b[2:0]` for SET/RESET/TEST.
- `opcode`  in  4 (`alu_op`)  operation select.
- `out`  out  alu_width  registered result.
- `status_flag`  out  8  registered flags, bit 7 to bit 0: S Z Y H X P/V N C.

## Operation
- W = alu_width. `alu_op` encoding: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SLA=7, SRA=8, ROL=9, ROR=10, INC=11, DEC=12, SET=13, RESET=14, TEST=15.
- ADD: a+b mod 2^W.
  - C = carry out; H = carry out of bit 3; V = signed overflow; N=0.
- SUB: a−b mod 2^W.
  - C = borrow; H = borrow from bit 4; V = signed overflow; N=1.
- AND/OR/XOR: bitwise. C=0, N=0, H=1 for AND and 0 otherwise, P/V = even parity of the result (1 = even number of ones).
- SLL and SLA are identical: a << b, zero fill. Amount ≥ W gives 0.
- SRL: a >> b, zero fill. Amount ≥ W gives 0.
- SRA: arithmetic right shift with sign fill. Amount ≥ W gives all copies of a[W−1].
- Shifts use the full value of `b` as the amount. C = last bit shifted out; C=0 for amount 0 and for amount > W. SRA with amount ≥ W sets C = a[W−1]. P/V = parity, H=0, N=0.
- ROL/ROR: rotate by b mod W. P/V = parity, H=0, N=0.
  - C = result[0] for ROL, result[W−1] for ROR.
  - Effective amount 0 gives C=0.
- INC/DEC: a±1. H and V as for ADD/SUB with b=1; N=0 for INC, 1 for DEC; C keeps its previous registered value.
- SET: a with bit b[2:0] set. RESET: a with bit b[2:0] cleared. Both keep all previous flags.
- TEST: out = a. Z = ~a[b[2:0]], H=1, N=0, C kept; S, Y, X, P/V computed from `out`.
- All ops unless stated otherwise:
  - S = out[W−1]; Z = (out==0); Y = out[5]; X = out[3].
  - For arithmetic ops, P/V = overflow; for all others, P/V = parity.

## Timing
- One-cycle latency: operands and opcode present before edge N produce `out` and `status_flag` valid after edge N.
- Result and flags are computed combinationally and registered. There are no combinational paths to the outputs.
- `reset`=1 at an edge clears `out` and `status_flag` to 0, overriding `enable`.
- Reset asserted mid-stream discards the in-flight operation.
- `enable`=0 holds both registers, including C, for later INC/DEC/SET/RESET/TEST.
- Back-to-back enabled cycles are fully pipelined, one result per cycle. There is no handshake.

## Structure
- `alu_op` enum (4-bit, values above) and flag bit-index constants (FLAG_S=7 … FLAG_C=0) go in the shared package `alu_pkg`, used by the decoder and test benches.
- One natural sub-module: `alu_shifter` (combinational SLL/SRL/SRA/ROL/ROR plus carry-out). Adder/subtractor, logic ops and flag/register logic stay in `z80_alu`.

## Test plan
- ADD 7+7 → 14. ADD 0xFF+0x01 → 0x00 with Z=1, C=1, H=1. ADD 0x70+0x47 → 0xB7 with V=1, S=1. ADD 0xFF+0x80 → 0x7F with V=1, C=1.
- SUB 7−7 → 0 with Z=1, N=1. SUB 0xFE−0xFF → 0xFF with C=1. SUB 0x0D−0x10 → 0xFD. SUB 0x80−0x01 → 0x7F with V=1. SUB 0x00−0xFF → 0x01 with C=1.
- Logic: AND 0x0D,0x07 → 0x05. OR 0xCB,0x2B → 0xEB. XOR 0xFF,0x8A → 0x75. XOR 7,7 → 0 with Z=1, P/V=1.
- Shifts:
  - SLL 0x07 by 3 → 0x38; SLL 0x0F by 6 → 0xC0; SLL 0x0F by 9 → 0x00.
  - SRL 0xCA by 3 → 0x19; SRL 0xCA by 8 → 0.
  - SRA 0xCA by 3 → 0xF9; SRA 0x4A by 3 → 0x09; SRA 0xCA by 8 → 0xFF.
  - SLL 0x02 by 0 → P/V=0; SLL 0x03 by 0 → P/V=1.
- Rotates: ROL 0xCA by 3 → 0x56. ROL 0x80 by 10 → 0x02. ROR 0xCA by 3 → 0x59. ROR 0x80 by 10 → 0x20.
- Control and bit ops:
  - Reset mid-stream → `out`=0, `status_flag`=0 after the edge.
  - `enable`=0 for 3 cycles while inputs toggle → outputs hold.
  - After C=1: INC 0xFF → 0x00 with C still 1. SET 0x00 bit 7 → 0x80. TEST 0x80 bit 6 → Z=1.
